// File: rtl/gn_pkg.sv
// Shared definitions for the mesh-router input port.
// Contents:
//   - output port codes (R, L, U, D, EJ) and the "no port" code
//   - requester state encoding
//   - xy_route(): dimension-ordered (X first, then Y) route selection
package gn_pkg;

    localparam logic [2:0] P_R    = 3'd0;
    localparam logic [2:0] P_L    = 3'd1;
    localparam logic [2:0] P_U    = 3'd2;
    localparam logic [2:0] P_D    = 3'd3;
    localparam logic [2:0] P_EJ   = 3'd4;
    localparam logic [2:0] P_NONE = 3'd7;

    // Coordinates are zero-extended to this width before routing, so one
    // function serves any X_W/Y_W up to 8 bits.
    localparam int COORD_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // X is resolved completely before Y; a packet that has arrived ejects.
    function automatic logic [2:0] xy_route(
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [COORD_W-1:0] cur_x,
        input logic [COORD_W-1:0] cur_y
    );
        logic [2:0] r;
        if (dst_x > cur_x) begin
            r = P_R;
        end else if (dst_x < cur_x) begin
            r = P_L;
        end else if (dst_y > cur_y) begin
            r = P_U;
        end else if (dst_y < cur_y) begin
            r = P_D;
        end else begin
            r = P_EJ;
        end
        return r;
    endfunction

endpackage

// File: rtl/gn_input_port_if.sv
// Bundle of the input port's flit, request/grant and forward signals.
//   upstream : in_valid, in_ready, in_flit, in_head, in_tail
//   selector : req_valid, req_port (to it), ans_R/L/U/D/EJ (from it)
//   forward  : out_valid, out_flit, out_tail
// Modports: master = surrounding router / environment, slave = input port.
interface gn_input_port_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_flit;
    logic              in_head;
    logic              in_tail;

    logic              req_valid;
    logic [2:0]        req_port;
    logic [2:0]        ans_R;
    logic [2:0]        ans_L;
    logic [2:0]        ans_U;
    logic [2:0]        ans_D;
    logic [2:0]        ans_EJ;

    logic              out_valid;
    logic [DATA_W-1:0] out_flit;
    logic              out_tail;

    modport master (
        output in_valid, in_flit, in_head, in_tail,
        input  in_ready,
        input  req_valid, req_port,
        output ans_R, ans_L, ans_U, ans_D, ans_EJ,
        input  out_valid, out_flit, out_tail
    );

    modport slave (
        input  in_valid, in_flit, in_head, in_tail,
        output in_ready,
        output req_valid, req_port,
        input  ans_R, ans_L, ans_U, ans_D, ans_EJ,
        output out_valid, out_flit, out_tail
    );
endinterface

// File: rtl/gn_flit_fifo.sv
// Synchronous flit FIFO, no write-to-read bypass.
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties FIFO)
//   i_push, i_wdata   write request / word (ignored when full)
//   i_pop             read request (ignored when empty)
//   o_rdata           word at the read pointer (valid when !o_empty)
//   o_full, o_empty   occupancy flags
//   o_count           occupancy, 0..DEPTH
module gn_flit_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == CNT_W'(0));
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two) and count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gn_input_port.sv
// Per-input-port requester of the 5-port mesh router.
// Buffers flits, routes each head flit XY-style, requests the routed output
// from the switch-allocation selector and forwards the packet (wormhole)
// on every cycle the selector's grant word for that output names PORT_ID.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   cur_x, cur_y    this router's coordinates (static)
//   bus             flit in / request / grant / flit out bundle (slave side)
//   err_drop        one-cycle pulse when a stray non-head flit is discarded
module gn_input_port #(
    parameter logic [2:0] PORT_ID = 3'd0,
    parameter int         DATA_W  = 16,
    parameter int         X_W     = 3,
    parameter int         Y_W     = 3,
    parameter int         DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    gn_input_port_if.slave bus,
    output logic           err_drop
);
    import gn_pkg::*;

    localparam int FW    = DATA_W + 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [FW-1:0]     w_rdata;
    logic [DATA_W-1:0] w_rd_flit;
    logic              w_rd_head;
    logic              w_rd_tail;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_route;
    logic [2:0]        w_route_nxt;
    logic [2:0]        w_sel;
    logic              w_granted;
    logic              w_fwd;
    logic              w_drop;

    logic              r_req_valid;
    logic [2:0]        r_req_port;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_flit;
    logic              r_out_tail;
    logic              r_err_drop;

    assign bus.in_ready = (w_count != CNT_W'(DEPTH));
    assign w_push       = bus.in_valid && !w_full;
    assign {w_rd_tail, w_rd_head, w_rd_flit} = w_rdata;

    gn_flit_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({bus.in_tail, bus.in_head, bus.in_flit}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Pick the grant word of the output we are routed to; others are ignored.
    always_comb begin
        w_sel = P_NONE;
        case (r_route)
            P_R:     w_sel = bus.ans_R;
            P_L:     w_sel = bus.ans_L;
            P_U:     w_sel = bus.ans_U;
            P_D:     w_sel = bus.ans_D;
            P_EJ:    w_sel = bus.ans_EJ;
            default: w_sel = P_NONE;
        endcase
    end

    assign w_granted = (r_state == ST_REQ) && (w_sel == PORT_ID);

    // Next state, FIFO pop and the values the output registers load.
    always_comb begin
        w_state_nxt = r_state;
        w_route_nxt = r_route;
        w_pop       = 1'b0;
        w_fwd       = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_empty) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_rd_head) begin
                    // A body/tail flit with no open packet cannot be routed.
                    w_pop       = 1'b1;
                    w_drop      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    // Head stays in the FIFO; it is forwarded once granted.
                    w_route_nxt = xy_route(COORD_W'(w_rd_flit[X_W-1:0]),
                                           COORD_W'(w_rd_flit[X_W+Y_W-1:X_W]),
                                           COORD_W'(cur_x),
                                           COORD_W'(cur_y));
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_granted && !w_empty) begin
                    w_pop       = 1'b1;
                    w_fwd       = 1'b1;
                    w_state_nxt = w_rd_tail ? ST_IDLE : ST_REQ;
                end else begin
                    // No grant or nothing buffered: keep requesting.
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, route and all externally visible outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_route     <= P_NONE;
            r_req_valid <= 1'b0;
            r_req_port  <= P_NONE;
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_tail  <= 1'b0;
            r_err_drop  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_route     <= w_route_nxt;
            r_req_valid <= (w_state_nxt == ST_REQ);
            r_req_port  <= (w_state_nxt == ST_REQ) ? w_route_nxt : P_NONE;
            r_out_valid <= w_fwd;
            r_out_flit  <= w_fwd ? w_rd_flit : '0;
            r_out_tail  <= w_fwd && w_rd_tail;
            r_err_drop  <= w_drop;
        end
    end

    assign bus.req_valid = r_req_valid;
    assign bus.req_port  = r_req_port;
    assign bus.out_valid = r_out_valid;
    assign bus.out_flit  = r_out_flit;
    assign bus.out_tail  = r_out_tail;
    assign err_drop      = r_err_drop;

endmodule

// File: tb/tb_gn_input_port.sv
// Self-checking bench for gn_input_port (PORT_ID=1, router at (2,2)).
// A queue-level reference model predicts every output each cycle; a small
// selector model returns grant words one cycle after each request.
module tb_gn_input_port;
    import gn_pkg::*;

    localparam logic [2:0] PID   = 3'd1;
    localparam int         DEPTH = 4;

    typedef struct {
        logic [15:0] d;
        logic        h;
        logic        t;
    } flit_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] cur_x = 3'd2;
    logic [2:0] cur_y = 3'd2;
    logic       err_drop;

    gn_input_port_if #(.DATA_W(16)) ifc ();

    gn_input_port #(
        .PORT_ID (PID),
        .DATA_W  (16),
        .X_W     (3),
        .Y_W     (3),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .bus      (ifc),
        .err_drop (err_drop)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    bit    grant_en = 1'b0;
    bit    decoy = 1'b0;
    flit_t mq[$];
    flit_t out_log[$];
    bit    m_busy;
    logic [2:0] m_route;
    bit    m_acc;
    logic  e_in_ready, e_req_valid, e_out_valid, e_out_tail, e_err;
    logic [2:0]  e_req_port;
    logic [15:0] e_out_flit;

    // Selector: grants the requested output one cycle later when enabled;
    // in decoy mode the other outputs also carry PID, which must be ignored.
    function automatic logic [2:0] word_for(input logic [2:0] o);
        if (ifc.req_valid && ifc.req_port == o && grant_en) return PID;
        if (decoy && ifc.req_valid && ifc.req_port != o) return PID;
        return 3'd7;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ifc.ans_R <= 3'd7; ifc.ans_L <= 3'd7; ifc.ans_U <= 3'd7;
            ifc.ans_D <= 3'd7; ifc.ans_EJ <= 3'd7;
        end else begin
            ifc.ans_R  <= word_for(P_R);
            ifc.ans_L  <= word_for(P_L);
            ifc.ans_U  <= word_for(P_U);
            ifc.ans_D  <= word_for(P_D);
            ifc.ans_EJ <= word_for(P_EJ);
        end
    end

    function automatic logic [2:0] ans_of(input logic [2:0] r);
        case (r)
            3'd0:    return ifc.ans_R;
            3'd1:    return ifc.ans_L;
            3'd2:    return ifc.ans_U;
            3'd3:    return ifc.ans_D;
            3'd4:    return ifc.ans_EJ;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] ref_route(input logic [15:0] f);
        int dx, dy, cx, cy;
        dx = int'(f[2:0]); dy = int'(f[5:3]);
        cx = int'(cur_x);  cy = int'(cur_y);
        if (dx > cx) return 3'd0;
        if (dx < cx) return 3'd1;
        if (dy > cy) return 3'd2;
        if (dy < cy) return 3'd3;
        return 3'd4;
    endfunction

    // Reference model: advance one clock using the inputs about to be sampled.
    task automatic model_step();
        flit_t f;
        bit    granted;
        m_acc = 1'b0;
        e_out_valid = 1'b0;
        e_err = 1'b0;
        if (reset) begin
            mq.delete();
            m_busy = 1'b0;
            e_out_flit = 16'h0;
            e_out_tail = 1'b0;
        end else begin
            granted = m_busy && (ans_of(m_route) == PID);
            m_acc = ifc.in_valid && (mq.size() < DEPTH);
            if (granted && mq.size() > 0) begin
                f = mq.pop_front();
                e_out_valid = 1'b1;
                e_out_flit = f.d;
                e_out_tail = f.t;
                if (f.t) m_busy = 1'b0;
            end else if (!m_busy && mq.size() > 0) begin
                if (!mq[0].h) begin
                    void'(mq.pop_front());
                    e_err = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_route = ref_route(mq[0].d);
                end
            end
            if (m_acc) begin
                f.d = ifc.in_flit; f.h = ifc.in_head; f.t = ifc.in_tail;
                mq.push_back(f);
            end
        end
        e_in_ready  = (mq.size() < DEPTH);
        e_req_valid = m_busy;
        e_req_port  = m_busy ? m_route : 3'd7;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: predict, let the edge happen, compare everything.
    task automatic tick();
        flit_t f;
        model_step();
        @(posedge clk);
        #1;
        check("in_ready",  32'(ifc.in_ready),  32'(e_in_ready));
        check("req_valid", 32'(ifc.req_valid), 32'(e_req_valid));
        check("req_port",  32'(ifc.req_port),  32'(e_req_port));
        check("out_valid", 32'(ifc.out_valid), 32'(e_out_valid));
        check("err_drop",  32'(err_drop),      32'(e_err));
        if (e_out_valid) begin
            check("out_flit", 32'(ifc.out_flit), 32'(e_out_flit));
            check("out_tail", 32'(ifc.out_tail), 32'(e_out_tail));
        end
        if (ifc.out_valid === 1'b1) begin
            f.d = ifc.out_flit; f.h = 1'b0; f.t = ifc.out_tail;
            out_log.push_back(f);
        end
    endtask

    task automatic put(input logic [15:0] d, input logic h, input logic t);
        ifc.in_valid = 1'b1; ifc.in_flit = d; ifc.in_head = h; ifc.in_tail = t;
    endtask

    task automatic nothing();
        ifc.in_valid = 1'b0; ifc.in_flit = 16'h0; ifc.in_head = 1'b0; ifc.in_tail = 1'b0;
    endtask

    // Push one flit, retrying while the model says the FIFO is full.
    task automatic push_bounded(input logic [15:0] d, input logic h, input logic t);
        int n;
        n = 0;
        put(d, h, t);
        do begin
            tick();
            n++;
        end while (!m_acc && n < 30);
        if (!m_acc) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=0 expected=1");
        end
        nothing();
    endtask

    logic [15:0] route_flit [4] = '{16'h0012, 16'h0002, 16'h0022, 16'h0038};
    logic [2:0]  route_exp  [4] = '{3'd4, 3'd3, 3'd2, 3'd1};
    logic [15:0] full_flit  [5] = '{16'h4015, 16'h4001, 16'h4002, 16'h4003, 16'h4004};

    initial begin
        int tails;
        reset = 1'b1;
        nothing();
        tick();
        tick();
        reset = 1'b0;
        check("rst_req_port",  32'(ifc.req_port),  32'd7);
        check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_out_flit",  32'(ifc.out_flit),  32'd0);
        check("rst_err_drop",  32'(err_drop),      32'd0);

        // Single-flit packet to (5,2): route R, latency 1/2/3 cycles.
        grant_en = 1'b1;
        put(16'hA015, 1'b1, 1'b1);
        tick();
        nothing();
        tick();
        check("t1_req_valid", 32'(ifc.req_valid), 32'd1);
        check("t1_req_port",  32'(ifc.req_port),  32'd0);
        tick();
        check("t1_ans_R",     32'(ifc.ans_R),     32'd1);
        tick();
        check("t1_out_valid", 32'(ifc.out_valid), 32'd1);
        check("t1_out_flit",  32'(ifc.out_flit),  32'hA015);
        check("t1_out_tail",  32'(ifc.out_tail),  32'd1);
        tick();
        check("t1_req_idle",  32'(ifc.req_port),  32'd7);

        // Remaining route directions, with decoy grants on other outputs.
        decoy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(route_flit[i], 1'b1, 1'b1);
            tick();
            nothing();
            tick();
            check("route_lit", 32'(ifc.req_port), 32'(route_exp[i]));
            repeat (4) tick();
        end

        // 3-flit packet: grant withheld, granted, revoked once, granted again.
        grant_en = 1'b0;
        out_log.delete();
        put(16'h1015, 1'b1, 1'b0); tick();
        put(16'h2222, 1'b0, 1'b0); tick();
        put(16'h3333, 1'b0, 1'b1); tick();
        nothing();
        tick(); tick();
        grant_en = 1'b1; tick(); tick();
        grant_en = 1'b0; tick();
        grant_en = 1'b1;
        repeat (6) tick();
        tails = 0;
        foreach (out_log[i]) tails += int'(out_log[i].t);
        check("pk3_count", 32'(out_log.size()), 32'd3);
        if (out_log.size() == 3) begin
            check("pk3_f0", 32'(out_log[0].d), 32'h1015);
            check("pk3_f1", 32'(out_log[1].d), 32'h2222);
            check("pk3_f2", 32'(out_log[2].d), 32'h3333);
        end
        check("pk3_tails", 32'(tails), 32'd1);

        // Fill to DEPTH with no grant; the 5th flit waits upstream.
        grant_en = 1'b0;
        decoy = 1'b0;
        out_log.delete();
        for (int i = 0; i < 4; i++) push_bounded(full_flit[i], i == 0, 1'b0);
        check("full_ready", 32'(ifc.in_ready), 32'd0);
        put(full_flit[4], 1'b0, 1'b1);
        tick();
        check("hold5_ready", 32'(ifc.in_ready), 32'd0);
        grant_en = 1'b1;
        push_bounded(full_flit[4], 1'b0, 1'b1);
        repeat (10) tick();
        check("full_count", 32'(out_log.size()), 32'd5);
        if (out_log.size() == 5) begin
            for (int i = 0; i < 5; i++) check("full_order", 32'(out_log[i].d), 32'(full_flit[i]));
        end

        // Stray body flit in IDLE is dropped with a one-cycle pulse.
        grant_en = 1'b0;
        put(16'h5555, 1'b0, 1'b0);
        tick();
        nothing();
        tick();
        check("drop_pulse", 32'(err_drop),      32'd1);
        check("drop_noreq", 32'(ifc.req_valid), 32'd0);
        tick();
        check("drop_end",   32'(err_drop),      32'd0);

        // Reset with two flits of an open packet buffered.
        put(16'h6015, 1'b1, 1'b0); tick();
        put(16'h6001, 1'b0, 1'b0); tick();
        nothing();
        tick();
        check("mid_req", 32'(ifc.req_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_req_port",  32'(ifc.req_port),  32'd7);
        check("mrst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("mrst_in_ready",  32'(ifc.in_ready),  32'd1);
        grant_en = 1'b1;
        out_log.delete();
        repeat (5) tick();
        check("mrst_flushed", 32'(out_log.size()), 32'd0);
        put(16'h7015, 1'b1, 1'b1);
        tick();
        nothing();
        repeat (5) tick();
        check("post_rst_count", 32'(out_log.size()), 32'd1);
        if (out_log.size() == 1) check("post_rst_flit", 32'(out_log[0].d), 32'h7015);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound in case something stalls the stimulus.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
